// File: rtl/fp16_mul_scheduler.sv
// Round-robin issue scheduler sharing one FP16 multiplier core between NREQ requesters.
// An in-order owner-ID FIFO routes each core result to that requester's held response register.
module fp16_mul_scheduler #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [16*NREQ-1:0]   req_a,
  input  logic [16*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [16*NREQ-1:0]   rsp_data,
  input  logic                 mul_ready,
  output logic                 mul_start,
  output logic [15:0]          mul_a,
  output logic [15:0]          mul_b,
  input  logic                 mul_done,
  input  logic [15:0]          mul_result,
  output logic [IDW:0]         inflight,
  output logic                 err_orphan
);

  localparam logic [IDW:0]   FifoDepth = (IDW + 1)'(NREQ);
  localparam logic [IDW-1:0] LastId    = IDW'(NREQ - 1);

  // Wrap-around increment; NREQ need not be a power of two.
  function automatic logic [IDW-1:0] ptr_inc(input logic [IDW-1:0] p);
    return (p == LastId) ? '0 : p + 1'b1;
  endfunction

  logic [NREQ-1:0]     busy_q, busy_d;
  logic [IDW-1:0]      rr_q, rr_d;
  logic [IDW-1:0]      fifo_q [NREQ];
  logic [IDW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [IDW:0]        count_q, count_d;
  logic [NREQ-1:0]     rsp_valid_q, rsp_valid_d;
  logic [16*NREQ-1:0]  rsp_data_q;
  logic                mul_start_q;
  logic [15:0]         mul_a_q, mul_b_q;
  logic                err_q;

  logic [NREQ-1:0]     elig, grant;
  logic [IDW-1:0]      grant_id, cand, pop_id;
  logic                found, do_pop;

  // Round-robin search starting at rr; first eligible requester wins.
  always_comb begin
    elig     = req_valid & ~busy_q;
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    cand     = '0;
    if (rst_n && ena && mul_ready && (count_q < FifoDepth)) begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        cand = IDW'((32'(rr_q) + k) % NREQ);
        if (!found && elig[cand]) begin
          found    = 1'b1;
          grant_id = cand;
        end
      end
    end
    if (found) grant[grant_id] = 1'b1;
  end

  assign pop_id = fifo_q[rd_ptr_q];
  assign do_pop = mul_done && (count_q != '0);

  always_comb begin
    busy_d      = busy_q & ~(rsp_valid_q & rsp_ready);
    rsp_valid_d = rsp_valid_q & ~(rsp_valid_q & rsp_ready);
    if (do_pop) rsp_valid_d[pop_id] = 1'b1;
    busy_d = busy_d | grant;
    rr_d   = found ? ptr_inc(grant_id) : rr_q;
    count_d = count_q;
    case ({found, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q      <= '0;
      rr_q        <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      mul_start_q <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      busy_q      <= busy_d;
      rr_q        <= rr_d;
      rsp_valid_q <= rsp_valid_d;
      count_q     <= count_d;
      mul_start_q <= found;
      if (found) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
        mul_a_q  <= req_a[{grant_id, 4'b0000} +: 16];
        mul_b_q  <= req_b[{grant_id, 4'b0000} +: 16];
      end
      if (do_pop) begin
        rd_ptr_q                             <= ptr_inc(rd_ptr_q);
        rsp_data_q[{pop_id, 4'b0000} +: 16] <= mul_result;
      end
      // A result with no recorded owner cannot be routed; flag it permanently.
      if (mul_done && !do_pop) err_q <= 1'b1;
    end
  end

  // Storage only: stale entries are never read because count_q gates every pop.
  always_ff @(posedge clk) begin
    if (found) fifo_q[wr_ptr_q] <= grant_id;
  end

  assign req_ready  = grant;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign mul_start  = mul_start_q;
  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
  assign inflight   = count_q;
  assign err_orphan = err_q;

endmodule

// File: tb/tb_fp16_mul_scheduler.sv
// Bench for fp16_mul_scheduler: in-order core model (result = A^B) plus a queue-based
// reference model of grants, owner order and response holding, checked every cycle.
module tb_fp16_mul_scheduler;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic clk = 1'b0;
  logic rst_n, ena, mul_ready;
  logic [NREQ-1:0] req_valid, req_ready, rsp_valid, rsp_ready;
  logic [16*NREQ-1:0] req_a, req_b, rsp_data;
  logic mul_start;
  logic [15:0] mul_a, mul_b;
  logic mul_done = 1'b0;
  logic [15:0] mul_result = 16'h0;
  logic [IDW:0] inflight;
  logic err_orphan;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fp16_mul_scheduler #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .mul_ready(mul_ready), .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_done(mul_done), .mul_result(mul_result),
    .inflight(inflight), .err_orphan(err_orphan)
  );

  // Core model: fixed latency, in order, result = A ^ B.
  typedef struct { int unsigned due; logic [15:0] res; } op_t;
  op_t pend[$];
  int unsigned cyc = 0;
  int unsigned core_lat = 1;
  bit orphan_req = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    op_t op;
    mul_done   = 1'b0;
    mul_result = 16'h0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      mul_done   = 1'b1;
      mul_result = pend[0].res;
      void'(pend.pop_front());
    end else if (orphan_req) begin
      mul_done   = 1'b1;
      mul_result = 16'hBEEF;
    end
    if (mul_start === 1'b1) begin
      op.due = cyc + core_lat;
      op.res = mul_a ^ mul_b;
      pend.push_back(op);
    end
  end

  // Reference model state.
  logic [NREQ-1:0] m_busy, m_rsp_valid;
  int m_rr;
  int m_fifo[$];
  logic [15:0] m_res[NREQ];
  logic [15:0] m_rsp_data[NREQ];
  logic m_err, m_start;
  logic [15:0] m_a, m_b;

  function automatic logic [NREQ-1:0] exp_grant();
    logic [NREQ-1:0] g = '0;
    if (rst_n && ena && mul_ready && m_fifo.size() < NREQ) begin
      for (int k = 0; k < NREQ; k++) begin
        int i = (m_rr + k) % NREQ;
        if (g == '0 && req_valid[i] && !m_busy[i]) g[i] = 1'b1;
      end
    end
    return g;
  endfunction

  task automatic model_edge();
    logic [NREQ-1:0] g = exp_grant();
    if (!rst_n) begin
      m_busy = '0; m_rsp_valid = '0; m_rr = 0; m_fifo.delete();
      m_err = 1'b0; m_start = 1'b0; m_a = '0; m_b = '0;
      for (int i = 0; i < NREQ; i++) m_rsp_data[i] = '0;
      return;
    end
    for (int i = 0; i < NREQ; i++)
      if (m_rsp_valid[i] && rsp_ready[i]) begin
        m_rsp_valid[i] = 1'b0;
        m_busy[i]      = 1'b0;
      end
    if (mul_done) begin
      if (m_fifo.size() > 0) begin
        int h = m_fifo.pop_front();
        m_rsp_valid[h] = 1'b1;
        m_rsp_data[h]  = m_res[h];
      end else m_err = 1'b1;
    end
    m_start = (g != '0);
    for (int i = 0; i < NREQ; i++)
      if (g[i]) begin
        m_busy[i] = 1'b1;
        m_fifo.push_back(i);
        m_rr     = (i + 1) % NREQ;
        m_a      = req_a[16*i +: 16];
        m_b      = req_b[16*i +: 16];
        m_res[i] = m_a ^ m_b;
      end
  endtask

  // Advance one cycle; returns at negedge+1 with the next cycle's registered state visible.
  task automatic tick();
    model_edge();
    @(negedge clk);
    #1;
  endtask

  task automatic drain();
    bit idle = 1'b0;
    req_valid = '0; rsp_ready = '1; ena = 1'b1; mul_ready = 1'b1;
    for (int c = 0; c < 40 && !idle; c++) begin
      #1;
      idle = (m_fifo.size() == 0 && m_rsp_valid == '0 && pend.size() == 0);
      if (!idle) tick();
    end
    n_checks++;
    if (inflight !== '0 || rsp_valid !== '0) begin
      n_fail++;
      $display("FAIL drain: inflight=%0d rsp_valid=%b, required 0 and 0000", inflight, rsp_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b1; mul_ready = 1'b1; req_valid = '1; rsp_ready = '0;
    req_a = '0; req_b = '0;
    tick(); tick();
    n_checks++; if (req_ready !== '0) begin n_fail++; $display("FAIL rst_req_ready: got %b required 0", req_ready); end
    n_checks++; if (rsp_valid !== '0) begin n_fail++; $display("FAIL rst_rsp_valid: got %b required 0", rsp_valid); end
    n_checks++; if (rsp_data !== '0) begin n_fail++; $display("FAIL rst_rsp_data: got %h required 0", rsp_data); end
    n_checks++; if (mul_start !== 1'b0) begin n_fail++; $display("FAIL rst_mul_start: got %b required 0", mul_start); end
    n_checks++; if (mul_a !== '0 || mul_b !== '0) begin n_fail++; $display("FAIL rst_mul_ab: got %h/%h required 0/0", mul_a, mul_b); end
    n_checks++; if (inflight !== '0) begin n_fail++; $display("FAIL rst_inflight: got %0d required 0", inflight); end
    n_checks++; if (err_orphan !== 1'b0) begin n_fail++; $display("FAIL rst_err_orphan: got %b required 0", err_orphan); end
    rst_n = 1'b1; req_valid = '0;
    tick();
  endtask

  task automatic test_fairness();
    int cnt[NREQ];
    logic [NREQ-1:0] one = 1;
    for (int i = 0; i < NREQ; i++) cnt[i] = 0;
    core_lat = 1; req_valid = '1; rsp_ready = '1; ena = 1'b1; mul_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      req_a = {$urandom(), $urandom()};
      req_b = {$urandom(), $urandom()};
      #1;
      n_checks++;
      if (req_ready !== exp_grant()) begin
        n_fail++; $display("FAIL fair_grant c%0d: got %b required %b", c, req_ready, exp_grant());
      end
      if (c < 4) begin
        n_checks++;
        if (req_ready !== (one << c)) begin
          n_fail++; $display("FAIL fair_order c%0d: got %b required %b", c, req_ready, one << c);
        end
      end
      n_checks++;
      if (inflight !== IDW'(m_fifo.size())) begin
        n_fail++; $display("FAIL fair_inflight c%0d: got %0d required %0d", c, inflight, m_fifo.size());
      end
      for (int i = 0; i < NREQ; i++) if (req_ready[i]) cnt[i]++;
      tick();
    end
    for (int i = 0; i < NREQ; i++) begin
      n_checks++;
      if (cnt[i] < 8) begin n_fail++; $display("FAIL fair_starve r%0d: got %0d grants required >=8", i, cnt[i]); end
    end
    drain();
  endtask

  task automatic test_single();
    core_lat = 3; rsp_ready = '0; ena = 1'b1; mul_ready = 1'b1;
    req_valid = 4'b0010;
    req_a[31:16] = 16'h3C00; req_b[31:16] = 16'h4000;
    #1;
    n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL single_grant: got %b required 0010", req_ready); end
    tick();
    req_valid = '0;
    n_checks++;
    if (mul_start !== 1'b1 || mul_a !== 16'h3C00 || mul_b !== 16'h4000) begin
      n_fail++; $display("FAIL single_issue: got start=%b a=%h b=%h required 1 3c00 4000", mul_start, mul_a, mul_b);
    end
    n_checks++; if (inflight !== 3'd1) begin n_fail++; $display("FAIL single_inflight1: got %0d required 1", inflight); end
    tick();
    for (int k = 2; k <= 4; k++) begin
      n_checks++;
      if (rsp_valid[1] !== 1'b0 || inflight !== 3'd1 || mul_start !== 1'b0) begin
        n_fail++; $display("FAIL single_wait t+%0d: rsp_valid=%b inflight=%0d start=%b required 0 1 0", k, rsp_valid[1], inflight, mul_start);
      end
      tick();
    end
    n_checks++;
    if (rsp_valid[1] !== 1'b1 || rsp_data[31:16] !== 16'h7C00) begin
      n_fail++; $display("FAIL single_rsp: got valid=%b data=%h required 1 7c00", rsp_valid[1], rsp_data[31:16]);
    end
    n_checks++; if (inflight !== 3'd0) begin n_fail++; $display("FAIL single_inflight0: got %0d required 0", inflight); end
    rsp_ready[1] = 1'b1;
    tick();
    n_checks++;
    if (rsp_valid[1] !== 1'b0 || rsp_data[31:16] !== 16'h7C00) begin
      n_fail++; $display("FAIL single_accept: got valid=%b data=%h required 0 7c00", rsp_valid[1], rsp_data[31:16]);
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [NREQ-1:0] e = '0;
    mul_ready = 1'b0; req_valid = '1; rsp_ready = '1; ena = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_checks++;
      if (req_ready !== '0 || mul_start !== 1'b0) begin
        n_fail++; $display("FAIL bp_block c%0d: got ready=%b start=%b required 0000 0", c, req_ready, mul_start);
      end
      tick();
    end
    mul_ready = 1'b1;
    e[m_rr] = 1'b1;
    #1;
    n_checks++; if (req_ready !== e) begin n_fail++; $display("FAIL bp_resume: got %b required %b", req_ready, e); end
    tick();
    drain();
  endtask

  task automatic test_held_response();
    logic [15:0] a[NREQ], b[NREQ];
    logic [15:0] exp2;
    int others = 0;
    bit seen = 1'b0;
    core_lat = 1;
    for (int i = 0; i < NREQ; i++) begin
      a[i] = 16'($urandom()); b[i] = 16'($urandom());
      req_a[16*i +: 16] = a[i]; req_b[16*i +: 16] = b[i];
    end
    exp2 = a[2] ^ b[2];
    req_valid = '1; rsp_ready = 4'b1011; ena = 1'b1; mul_ready = 1'b1;
    for (int c = 0; c < 20 && !seen; c++) begin
      #1;
      n_checks++;
      if (req_ready !== exp_grant()) begin n_fail++; $display("FAIL held_grant: got %b required %b", req_ready, exp_grant()); end
      if (rsp_valid[2] === 1'b1) seen = 1'b1;
      else tick();
    end
    n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL held_wait: rsp_valid[2]=%b required 1 within 20 cycles", rsp_valid[2]); end
    for (int c = 0; c < 10; c++) begin
      if (c > 0) #1;
      n_checks++;
      if (rsp_valid[2] !== 1'b1 || rsp_data[47:32] !== exp2 || req_ready[2] !== 1'b0) begin
        n_fail++; $display("FAIL held_hold c%0d: valid=%b data=%h ready2=%b required 1 %h 0", c, rsp_valid[2], rsp_data[47:32], req_ready[2], exp2);
      end
      others += (req_ready & 4'b1011) != '0 ? 1 : 0;
      tick();
    end
    n_checks++; if (others == 0) begin n_fail++; $display("FAIL held_others: got %0d grants required >0", others); end
    rsp_ready[2] = 1'b1;
    #1;
    n_checks++;
    if (req_ready[2] !== 1'b0 || rsp_valid[2] !== 1'b1) begin
      n_fail++; $display("FAIL held_accept: ready2=%b valid=%b required 0 1", req_ready[2], rsp_valid[2]);
    end
    tick();
    n_checks++;
    if (rsp_valid[2] !== 1'b0 || req_ready !== exp_grant()) begin
      n_fail++; $display("FAIL held_after: valid=%b ready=%b required 0 %b", rsp_valid[2], req_ready, exp_grant());
    end
    tick();
    drain();
  endtask

  task automatic test_orphan();
    req_valid = '0; rsp_ready = '0;
    orphan_req = 1'b1;
    tick();
    orphan_req = 1'b0;
    tick();
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if (err_orphan !== 1'b1 || rsp_valid !== '0) begin
        n_fail++; $display("FAIL orphan c%0d: err=%b rsp_valid=%b required 1 0000", c, err_orphan, rsp_valid);
      end
      tick();
    end
  endtask

  task automatic test_mid_reset();
    core_lat = 4; req_valid = 4'b0111; rsp_ready = '1; ena = 1'b1; mul_ready = 1'b1;
    req_a = {$urandom(), $urandom()}; req_b = {$urandom(), $urandom()};
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if (req_ready !== exp_grant()) begin n_fail++; $display("FAIL mid_grant c%0d: got %b required %b", c, req_ready, exp_grant()); end
      tick();
    end
    n_checks++; if (inflight !== 3'd3) begin n_fail++; $display("FAIL mid_inflight3: got %0d required 3", inflight); end
    rst_n = 1'b0; req_valid = '0;
    tick();
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (rsp_valid !== '0 || mul_start !== 1'b0 || inflight !== '0 || err_orphan !== 1'b0 || req_ready !== '0) begin
      n_fail++; $display("FAIL mid_reset: rsp_valid=%b start=%b inflight=%0d err=%b ready=%b required all 0",
                         rsp_valid, mul_start, inflight, err_orphan, req_ready);
    end
    for (int c = 0; c < 10 && pend.size() > 0; c++) begin
      n_checks++;
      if (rsp_valid !== '0) begin n_fail++; $display("FAIL mid_no_rsp c%0d: got %b required 0000", c, rsp_valid); end
      tick();
    end
    tick();
    n_checks++; if (err_orphan !== 1'b1) begin n_fail++; $display("FAIL mid_orphan: got %b required 1", err_orphan); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; req_valid = '1;
    #1;
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL mid_rr0: got %b required 0001", req_ready); end
    tick();
    drain();
  endtask

  task automatic test_random();
    core_lat = 2;
    for (int c = 0; c < 300; c++) begin
      req_valid = NREQ'($urandom());
      rsp_ready = NREQ'($urandom());
      req_a = {$urandom(), $urandom()}; req_b = {$urandom(), $urandom()};
      mul_ready = ($urandom_range(0, 3) != 0);
      ena = ($urandom_range(0, 7) != 0);
      #1;
      n_checks++;
      if (req_ready !== exp_grant()) begin n_fail++; $display("FAIL rnd_grant c%0d: got %b required %b", c, req_ready, exp_grant()); end
      n_checks++;
      if (inflight !== IDW'(m_fifo.size())) begin n_fail++; $display("FAIL rnd_inflight c%0d: got %0d required %0d", c, inflight, m_fifo.size()); end
      n_checks++;
      if (rsp_valid !== m_rsp_valid) begin n_fail++; $display("FAIL rnd_rsp_valid c%0d: got %b required %b", c, rsp_valid, m_rsp_valid); end
      n_checks++;
      if (mul_start !== m_start) begin n_fail++; $display("FAIL rnd_start c%0d: got %b required %b", c, mul_start, m_start); end
      if (m_start) begin
        n_checks++;
        if (mul_a !== m_a || mul_b !== m_b) begin n_fail++; $display("FAIL rnd_operands c%0d: got %h/%h required %h/%h", c, mul_a, mul_b, m_a, m_b); end
      end
      for (int i = 0; i < NREQ; i++)
        if (m_rsp_valid[i]) begin
          n_checks++;
          if (rsp_data[16*i +: 16] !== m_rsp_data[i]) begin
            n_fail++; $display("FAIL rnd_data c%0d r%0d: got %h required %h", c, i, rsp_data[16*i +: 16], m_rsp_data[i]);
          end
        end
      n_checks++;
      if (err_orphan !== m_err) begin n_fail++; $display("FAIL rnd_err c%0d: got %b required %b", c, err_orphan, m_err); end
      tick();
    end
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_fairness();
    test_single();
    test_backpressure();
    test_held_response();
    test_orphan();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fp16_mul_scheduler.md
# fp16_mul_scheduler

Round-robin scheduler that shares one FP16 logarithmic-approximation multiplier core between NREQ requesters. Each requester presents a pair of 16-bit operands with a valid/ready handshake. The block issues at most one operation per cycle to the core and tracks in-flight owners in an in-order ID FIFO. It routes each core result to a per-requester response register, where the result is held until that requester accepts it. It sits between the requester-side control logic and the multiplier datapath.

## Interface
- NREQ, 4: number of requesters (2..8).
- IDW, $clog2(NREQ): owner ID width.
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- ena  in  1  grant enable; when low, no new grants (completions still processed).
- req_valid  in  NREQ  request valid, one bit per requester.
- req_ready  out  NREQ  one-hot grant, combinational; reset 0.
- req_a  in  16*NREQ  operand A of requester i at [16i+:16].
- req_b  in  16*NREQ  operand B of requester i at [16i+:16].
- rsp_valid  out  NREQ  result held for requester i; reset 0.
- rsp_ready  in  NREQ  requester accepts result.
- rsp_data  out  16*NREQ  result of requester i at [16i+:16]; reset 0.
- mul_ready  in  1  core can accept a start in the next cycle.
- mul_start  out  1  single-cycle issue strobe, registered; reset 0.
- mul_a, mul_b  out  16  operands issued with mul_start, registered; reset 0.
- mul_done  in  1  core result valid, in issue order.
- mul_result  in  16  core result.
- inflight  out  IDW+1  FIFO occupancy; reset 0.
- err_orphan  out  1  sticky: mul_done seen with empty FIFO; reset 0.

## Operation
- busy[i] register:
  - Set on the grant to requester i.
  - Cleared on the rsp_valid[i] & rsp_ready[i] handshake.
  - Limits each requester to one outstanding operation.
- Eligibility: elig = req_valid & ~busy.
- Grant condition: ena & mul_ready & (inflight < NREQ) & |elig.
- Grant selection: round-robin starting from pointer rr. After a grant to requester g, rr = (g+1) mod NREQ. rr resets to 0.
- On grant g:
  - req_a[g] / req_b[g] are latched into mul_a / mul_b.
  - mul_start = 1 in the next cycle only.
  - ID g is pushed into the FIFO.
  - busy[g] is set.
- mul_start is low in every cycle not following a grant. mul_a / mul_b hold their last values.
- On mul_done with a non-empty FIFO:
  - Pop ID h.
  - rsp_data[h] <= mul_result and rsp_valid[h] <= 1.
- On mul_done with an empty FIFO: the result is dropped and err_orphan <= 1 until reset.
- A push and a pop in the same cycle leave inflight unchanged. The FIFO (depth NREQ, wrap-around pointers) cannot overflow because of the busy bits. The full check remains as a guard.
- rsp_valid[i] falls the cycle after the handshake. rsp_data[i] holds its value until overwritten.
- The block does not inspect operands or results: sign, exponent and mantissa handling is entirely in the core.

## Timing
- Grant at cycle t (combinational req_ready, transfer when req_valid & req_ready):
  - mul_start at t+1.
  - inflight increments at t+1.
- Core done at cycle d → rsp_valid at d+1 (one-cycle registered path).
- A rsp handshake at cycle r clears busy at r+1. That requester can be granted again at r+1 at the earliest, even if req_valid was high at r.
- Throughput: one issue per cycle while mul_ready is high and distinct requesters are eligible.
- mul_ready low at t blocks grants at t. ena low blocks grants but pops, responses and rsp handshakes continue.
- Reset asserted mid-operation:
  - Clears the FIFO, busy, rr, all rsp_valid and mul_start at the next edge.
  - Core results arriving afterwards raise err_orphan. The core must be reset together with this block.

## Test plan
- Single request:
  - Stimulus: req_valid[1]=1, A=0x3C00, B=0x4000; bench core model with latency 3, result = A^B.
  - Required: req_ready[1] at t; mul_start at t+1 with mul_a=0x3C00, mul_b=0x4000; rsp_valid[1] with rsp_data=0x7C00 at t+5; inflight goes 1→0.
- Fairness:
  - Stimulus: all 4 valid continuously, rsp_ready=1, core latency 1.
  - Required: grant order 0,1,2,3 then requester 0 regranted only after its busy bit clears; no requester starved over 40 cycles.
- Backpressure:
  - Stimulus: mul_ready=0 for 5 cycles while all requesters are valid.
  - Required: no req_ready and no mul_start during those 5 cycles; first grant to rr in the cycle mul_ready returns.
- Held response:
  - Stimulus: rsp_ready[2]=0 for 10 cycles after the result arrives.
  - Required: rsp_valid[2] and rsp_data stable for all 10 cycles; requester 2 not granted again until 1 cycle after acceptance; other requesters keep issuing.
- Orphan:
  - Stimulus: pulse mul_done with inflight=0.
  - Required: err_orphan=1 and stays high; no rsp_valid changes; cleared only by rst_n low at a clock edge.
- Mid-operation reset:
  - Stimulus: 3 ops in flight, then rst_n=0 for one edge.
  - Required: all outputs at reset values next cycle; inflight=0; rr=0.
